// File: rtl/spi_pi_bridge.sv
// SPI (mode 0) target that turns Pi command frames into single-cycle parallel bus reads/writes.
// Optional build macro SPI_BURST_EN: WRITE frames stream data bytes to incrementing addresses.
module spi_pi_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [15:0] pi_addr,
    output logic [7:0]  pi_data,
    output logic        pi_write,
    output logic        pi_read,
    input  logic [7:0]  pi_data_in
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR_HI, S_ADDR_LO, S_WDATA, S_TURN, S_RDATA, S_IGNORE
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h80;
    localparam logic [7:0] CMD_READ  = 8'hC0;

    state_t      r_state, w_next;
    logic [1:0]  r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic        r_sclk_d, r_armed;
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_rx;
    logic [7:0]  r_tx;
    logic        r_is_read, r_wr_go, r_rd_go, r_show;
`ifdef SPI_BURST_EN
    logic        r_wr_d;
`endif

    logic        w_sclk, w_cs_n, w_mosi, w_rise, w_fall, w_byte_done;
    logic [7:0]  w_rx_byte;
    logic        w_ld_cmd, w_ld_hi, w_ld_lo, w_ld_data, w_rd_go, w_enter_rdata, w_shift;

    assign w_sclk    = r_sclk_sync[1];
    assign w_cs_n    = r_cs_sync[1];
    assign w_mosi    = r_mosi_sync[1];
    assign w_rise    = w_sclk & ~r_sclk_d;
    assign w_fall    = ~w_sclk & r_sclk_d;
    assign w_rx_byte = {r_rx, w_mosi};
    assign w_byte_done = w_rise && (r_bit_cnt == 3'd7) && !w_cs_n && (r_state != S_IDLE);

    // CS sync resets to "low" and r_armed clears, so a frame cut by reset is ignored
    // until CS is seen high again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_sync <= 2'b00;
            r_cs_sync   <= 2'b00;
            r_mosi_sync <= 2'b00;
            r_sclk_d    <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], spi_sclk};
            r_cs_sync   <= {r_cs_sync[0], spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
            r_sclk_d    <= w_sclk;
            if (w_cs_n)
                r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= 3'd0;
            r_rx      <= 7'd0;
        end else if (w_cs_n || r_state == S_IDLE) begin
            r_bit_cnt <= 3'd0;
        end else if (w_rise) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_rx      <= {r_rx[5:0], w_mosi};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_cs_n) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (r_armed) w_next = S_CMD;
                S_CMD:     if (w_byte_done)
                               w_next = (w_rx_byte == CMD_WRITE || w_rx_byte == CMD_READ)
                                        ? S_ADDR_HI : S_IGNORE;
                S_ADDR_HI: if (w_byte_done) w_next = S_ADDR_LO;
                S_ADDR_LO: if (w_byte_done) w_next = r_is_read ? S_TURN : S_WDATA;
`ifdef SPI_BURST_EN
                S_WDATA:   w_next = S_WDATA;
`else
                S_WDATA:   if (w_byte_done) w_next = S_IGNORE;
`endif
                S_TURN:    if (w_byte_done) w_next = S_RDATA;
                S_RDATA:   if (w_byte_done) w_next = S_IGNORE;
                S_IGNORE:  w_next = S_IGNORE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_ld_cmd      = 1'b0;
        w_ld_hi       = 1'b0;
        w_ld_lo       = 1'b0;
        w_ld_data     = 1'b0;
        w_rd_go       = 1'b0;
        w_enter_rdata = 1'b0;
        w_shift       = 1'b0;
        case (r_state)
            S_CMD:     w_ld_cmd = w_byte_done;
            S_ADDR_HI: w_ld_hi  = w_byte_done;
            S_ADDR_LO: begin
                w_ld_lo = w_byte_done;
                w_rd_go = w_byte_done & r_is_read;
            end
            S_WDATA:   w_ld_data     = w_byte_done;
            S_TURN:    w_enter_rdata = w_byte_done;
            // Bit 7 is already on MISO when RDATA starts; shift only after the first rise.
            S_RDATA:   w_shift = w_fall && (r_bit_cnt != 3'd0) && !w_cs_n;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pi_addr   <= 16'h0000;
            pi_data   <= 8'h00;
            pi_write  <= 1'b0;
            pi_read   <= 1'b0;
            spi_miso  <= 1'b0;
            r_tx      <= 8'h00;
            r_is_read <= 1'b0;
            r_wr_go   <= 1'b0;
            r_rd_go   <= 1'b0;
            r_show    <= 1'b0;
`ifdef SPI_BURST_EN
            r_wr_d    <= 1'b0;
`endif
        end else begin
            r_wr_go  <= w_ld_data;
            pi_write <= r_wr_go;
            r_rd_go  <= w_rd_go;
            pi_read  <= r_rd_go;
            r_show   <= w_enter_rdata | w_shift;
            if (w_ld_cmd)
                r_is_read <= (w_rx_byte == CMD_READ);
            if (w_ld_hi)
                pi_addr[15:8] <= w_rx_byte;
            else if (w_ld_lo)
                pi_addr[7:0] <= w_rx_byte;
`ifdef SPI_BURST_EN
            else if (r_wr_d)
                pi_addr <= pi_addr + 16'd1;
            r_wr_d <= pi_write;
`endif
            if (w_ld_data)
                pi_data <= w_rx_byte;
            if (pi_read)
                r_tx <= pi_data_in;
            else if (w_shift)
                r_tx <= {r_tx[6:0], 1'b0};
            if (r_show)
                spi_miso <= r_tx[7];
            else if (r_state != S_RDATA)
                spi_miso <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_pi_bridge.sv
// Directed bench for spi_pi_bridge: write, read, abort, invalid command, burst and mid-frame reset.
module tb_spi_pi_bridge;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        reset, spi_sclk, spi_cs_n, spi_mosi, spi_miso;
    logic [15:0] pi_addr;
    logic [7:0]  pi_data;
    logic        pi_write, pi_read;
    logic [7:0]  pi_data_in;

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          both_cnt = 0;
    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];
    logic [15:0] ra_last;
    logic [7:0]  tx_buf[8];
    logic [7:0]  rx_buf[8];
    logic [7:0]  rx_or;
    logic [7:0]  dummy;

    spi_pi_bridge dut (
        .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .pi_addr(pi_addr), .pi_data(pi_data),
        .pi_write(pi_write), .pi_read(pi_read), .pi_data_in(pi_data_in)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pi_write) begin
            wr_cnt++;
            wa_q.push_back(pi_addr);
            wd_q.push_back(pi_data);
        end
        if (pi_read) begin
            rd_cnt++;
            ra_last = pi_addr;
        end
        if (pi_write && pi_read)
            both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] wa(input int i);
        return (wa_q.size() > i) ? wa_q[i] : 16'hxxxx;
    endfunction

    function automatic logic [7:0] wd(input int i);
        return (wd_q.size() > i) ? wd_q[i] : 8'hxx;
    endfunction

    task automatic clear_log();
        wr_cnt = 0;
        rd_cnt = 0;
        ra_last = 16'hxxxx;
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = spi_miso;
            spi_sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic frame(input int n);
        rx_or = 8'h00;
        cs_low();
        for (int i = 0; i < n; i++)
            spi_bits(tx_buf[i], 8, rx_buf[i]);
        cs_high();
    endtask

    initial begin
        reset = 1'b1;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        pi_data_in = 8'h00;
        repeat (4) @(negedge clk);
        chk("rst_addr", pi_addr, 16'h0000);
        chk("rst_data", pi_data, 8'h00);
        chk("rst_wr", pi_write, 1'b0);
        chk("rst_rd", pi_read, 1'b0);
        chk("rst_miso", spi_miso, 1'b0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // WRITE E803 = 08
        clear_log();
        tx_buf[0] = 8'h80; tx_buf[1] = 8'hE8; tx_buf[2] = 8'h03; tx_buf[3] = 8'h08;
        frame(4);
        chk("wr_cnt", wr_cnt, 1);
        chk("wr_rdcnt", rd_cnt, 0);
        chk("wr_addr", wa(0), 16'hE803);
        chk("wr_data", wd(0), 8'h08);
        chk("wr_miso", {rx_buf[0], rx_buf[1], rx_buf[2], rx_buf[3]}, 32'h0);
        chk("wr_hold", pi_addr, 16'hE803);

        // READ 8000 -> 5A
        clear_log();
        pi_data_in = 8'h5A;
        tx_buf[0] = 8'hC0; tx_buf[1] = 8'h80; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00; tx_buf[4] = 8'h00;
        frame(5);
        chk("rd_cnt", rd_cnt, 1);
        chk("rd_wrcnt", wr_cnt, 0);
        chk("rd_addr", ra_last, 16'h8000);
        chk("rd_miso03", {rx_buf[0], rx_buf[1], rx_buf[2], rx_buf[3]}, 32'h0);
        chk("rd_miso4", rx_buf[4], 8'h5A);

        // READ 1234 -> C3, turnaround MOSI ignored
        clear_log();
        pi_data_in = 8'hC3;
        tx_buf[0] = 8'hC0; tx_buf[1] = 8'h12; tx_buf[2] = 8'h34; tx_buf[3] = 8'hFF; tx_buf[4] = 8'hFF;
        frame(5);
        chk("rd2_cnt", rd_cnt, 1);
        chk("rd2_addr", ra_last, 16'h1234);
        chk("rd2_miso3", rx_buf[3], 8'h00);
        chk("rd2_miso4", rx_buf[4], 8'hC3);

        // Abort mid data byte, then a full write succeeds
        clear_log();
        cs_low();
        spi_bits(8'h80, 8, dummy);
        spi_bits(8'hE8, 8, dummy);
        spi_bits(8'h00, 8, dummy);
        spi_bits(8'hA0, 3, dummy);
        cs_high();
        chk("abort_wr", wr_cnt, 0);
        tx_buf[0] = 8'h80; tx_buf[1] = 8'hE8; tx_buf[2] = 8'h01; tx_buf[3] = 8'h55;
        frame(4);
        chk("post_abort_cnt", wr_cnt, 1);
        chk("post_abort_addr", wa(0), 16'hE801);
        chk("post_abort_data", wd(0), 8'h55);

        // Invalid command
        clear_log();
        tx_buf[0] = 8'h12; tx_buf[1] = 8'hAA; tx_buf[2] = 8'hBB; tx_buf[3] = 8'hCC; tx_buf[4] = 8'hDD;
        frame(5);
        chk("inv_wr", wr_cnt, 0);
        chk("inv_rd", rd_cnt, 0);
        chk("inv_miso", {rx_buf[1], rx_buf[2], rx_buf[3], rx_buf[4]}, 32'h0);
        chk("inv_hold", pi_addr, 16'hE801);

        // Burst attempt at FFFF
        clear_log();
        tx_buf[0] = 8'h80; tx_buf[1] = 8'hFF; tx_buf[2] = 8'hFF; tx_buf[3] = 8'hAA; tx_buf[4] = 8'h55;
        frame(5);
        chk("burst_a0", wa(0), 16'hFFFF);
        chk("burst_d0", wd(0), 8'hAA);
`ifdef SPI_BURST_EN
        chk("burst_cnt", wr_cnt, 2);
        chk("burst_a1", wa(1), 16'h0000);
        chk("burst_d1", wd(1), 8'h55);
`else
        chk("burst_cnt", wr_cnt, 1);
        chk("burst_hold", pi_addr, 16'hFFFF);
`endif

        // Reset during ADDR_LO
        clear_log();
        cs_low();
        spi_bits(8'h80, 8, dummy);
        spi_bits(8'h12, 8, dummy);
        spi_bits(8'h34, 4, dummy);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_addr", pi_addr, 16'h0000);
        chk("mrst_data", pi_data, 8'h00);
        chk("mrst_wr", pi_write, 1'b0);
        chk("mrst_rd", pi_read, 1'b0);
        chk("mrst_miso", spi_miso, 1'b0);
        spi_bits(8'h40, 4, dummy);
        spi_bits(8'h77, 8, dummy);
        cs_high();
        chk("mrst_nowr", wr_cnt, 0);
        chk("mrst_nord", rd_cnt, 0);
        chk("mrst_addr2", pi_addr, 16'h0000);
        tx_buf[0] = 8'h80; tx_buf[1] = 8'h12; tx_buf[2] = 8'h34; tx_buf[3] = 8'h77;
        frame(4);
        chk("after_rst_cnt", wr_cnt, 1);
        chk("after_rst_addr", wa(0), 16'h1234);
        chk("after_rst_data", wd(0), 8'h77);

        chk("no_overlap", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
